// File: rtl/data_mem_responder_pkg.sv
// Shared constants for the data-memory responder: I/O register offsets
// within the 16-byte window and the bit positions of the timer control register.
package data_mem_responder_pkg;

    localparam int TMR_WIDTH = 8;

    localparam logic [3:0] IO_GPIO_OUT  = 4'd0;
    localparam logic [3:0] IO_GPIO_IN   = 4'd1;
    localparam logic [3:0] IO_TMR_CTRL  = 4'd2;
    localparam logic [3:0] IO_TMR_PRESC = 4'd3;
    localparam logic [3:0] IO_TMR_COUNT = 4'd4;

    localparam int TMR_EN  = 0;
    localparam int TMR_CLR = 1;
    localparam int TMR_OV  = 2;

endpackage

// File: rtl/data_mem_responder_io_timer.sv
// Prescaled 8-bit timer with a sticky overflow flag; only present when
// DATA_MEM_TIMER_EN is defined.
`ifdef DATA_MEM_TIMER_EN
module io_timer
    import data_mem_responder_pkg::*;
(
    input  logic                 clk,
    input  logic                 arst,
    input  logic                 ctrl_we,
    input  logic                 presc_we,
    input  logic [TMR_WIDTH-1:0] wdata,
    output logic [TMR_WIDTH-1:0] count,
    output logic [TMR_WIDTH-1:0] presc,
    output logic                 en,
    output logic                 ov
);

    logic [TMR_WIDTH-1:0] presc_cnt;
    logic                 tick;
    logic                 clr;
    logic                 wrap;

    // A hardware wrap beats a same-cycle write-1-clear of the flag.
    always_comb begin
        tick = en && (presc_cnt == '0);
        clr  = ctrl_we && wdata[TMR_CLR];
        wrap = tick && !clr && (count == '1);
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            en        <= 1'b0;
            ov        <= 1'b0;
            presc     <= '0;
            presc_cnt <= '0;
            count     <= '0;
        end else begin
            if (ctrl_we)
                en <= wdata[TMR_EN];
            if (presc_we)
                presc <= wdata;

            // A fresh prescale value takes effect immediately, even on an expiry.
            if (clr)
                presc_cnt <= '0;
            else if (presc_we)
                presc_cnt <= wdata;
            else if (tick)
                presc_cnt <= presc;
            else if (en)
                presc_cnt <= presc_cnt - 1'b1;

            if (clr)
                count <= '0;
            else if (tick)
                count <= count + 1'b1;

            if (wrap)
                ov <= 1'b1;
            else if (ctrl_we && wdata[TMR_OV])
                ov <= 1'b0;
        end
    end

endmodule
`endif

// File: rtl/data_mem_responder.sv
// Data-memory responder: byte RAM below IO_BASE, GPIO and optional timer
// (enabled by DATA_MEM_TIMER_EN) in a 16-byte I/O window at IO_BASE.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    DATA_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] IO_BASE    = 8'hF0
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_data_o,
    input  logic                  mem_WE,
    output logic [DATA_WIDTH-1:0] mem_data_i,
    input  logic [DATA_WIDTH-1:0] gpio_in,
    output logic [DATA_WIDTH-1:0] gpio_out,
    output logic                  tmr_ov
);

    localparam int RAM_DEPTH = int'(IO_BASE);

    logic [DATA_WIDTH-1:0] ram [0:RAM_DEPTH-1];
    logic [DATA_WIDTH-1:0] sync1;
    logic [DATA_WIDTH-1:0] sync2;
    logic [ADDR_WIDTH-1:0] io_off;
    logic [3:0]            sel;
    logic                  is_ram;
    logic                  in_win;
    logic                  io_we;

    always_comb begin
        is_ram = mem_addr < IO_BASE;
        io_off = mem_addr - IO_BASE;
        in_win = !is_ram && (io_off < ADDR_WIDTH'(16));
        sel    = io_off[3:0];
        io_we  = mem_WE && in_win && !arst;
    end

    // RAM is never cleared; reset only suppresses a pending write.
    always_ff @(posedge clk) begin
        if (!arst && mem_WE && is_ram)
            ram[mem_addr] <= mem_data_o;
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            gpio_out <= '0;
            sync1    <= '0;
            sync2    <= '0;
        end else begin
            sync1 <= gpio_in;
            sync2 <= sync1;
            if (io_we && sel == IO_GPIO_OUT)
                gpio_out <= mem_data_o;
        end
    end

`ifdef DATA_MEM_TIMER_EN
    logic [TMR_WIDTH-1:0] tmr_count;
    logic [TMR_WIDTH-1:0] tmr_presc;
    logic                 tmr_en;
    logic                 tmr_ovf;
    logic [TMR_WIDTH-1:0] ctrl_rd;

    io_timer u_timer (
        .clk      (clk),
        .arst     (arst),
        .ctrl_we  (io_we && sel == IO_TMR_CTRL),
        .presc_we (io_we && sel == IO_TMR_PRESC),
        .wdata    (mem_data_o[TMR_WIDTH-1:0]),
        .count    (tmr_count),
        .presc    (tmr_presc),
        .en       (tmr_en),
        .ov       (tmr_ovf)
    );

    always_comb begin
        ctrl_rd         = '0;
        ctrl_rd[TMR_EN] = tmr_en;
        ctrl_rd[TMR_OV] = tmr_ovf;
    end

    assign tmr_ov = tmr_ovf;
`else
    assign tmr_ov = 1'b0;
`endif

    // Zero-latency read path; unmapped window offsets return 0.
    always_comb begin
        mem_data_i = '0;
        if (is_ram) begin
            mem_data_i = ram[mem_addr];
        end else if (in_win) begin
            case (sel)
                IO_GPIO_OUT:  mem_data_i = gpio_out;
                IO_GPIO_IN:   mem_data_i = sync2;
`ifdef DATA_MEM_TIMER_EN
                IO_TMR_CTRL:  mem_data_i = DATA_WIDTH'(ctrl_rd);
                IO_TMR_PRESC: mem_data_i = DATA_WIDTH'(tmr_presc);
                IO_TMR_COUNT: mem_data_i = DATA_WIDTH'(tmr_count);
`endif
                default:      mem_data_i = '0;
            endcase
        end
    end

endmodule
